prio_encoder_seq: RTL

- Encoder counterpart to the team's 3-to-8 enabled decoder: accepts an N-bit request vector and returns the index of each asserted line as a binary code.
- Multi-hot input is not collapsed. The vector is latched, then each set bit's index is emitted one per transfer, highest index first, over a valid/ready handshake.
- Sits between request/interrupt lines and any consumer expecting one code at a time, e.g. driving the decoder back to one-hot.

---
 rtl/prio_encoder_seq_pkg.sv | 12 +
 rtl/prio_encoder_seq_find_hi.sv | 26 ++
 rtl/prio_encoder_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/prio_encoder_seq_pkg.sv
// Shared constants and state encoding for the sequential priority encoder.
package prio_encoder_seq_pkg;

    localparam int N_REQ  = 8;
    localparam int W_CODE = 3;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

endpackage

// File: rtl/prio_encoder_seq_find_hi.sv
// Combinational search for the highest set bit of a vector; idx is 0 when
// the vector is empty, so callers qualify it with any.
module prio_find_hi
    import prio_encoder_seq_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = W_CODE
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan so the last hit, i.e. the highest index, wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/prio_encoder_seq.sv
// Latches a request vector and streams the index of every set bit,
// highest first, one code per valid/ready transfer.
module prio_encoder_seq
    import prio_encoder_seq_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = W_CODE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         ready,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         busy,
    output logic         done,
    output logic         none
);

    state_t       state;
    logic [N-1:0] pending;
    logic [W-1:0] hi_idx;
    logic         hi_any;
    logic [N-1:0] hi_mask;
    logic [N-1:0] remaining;

    prio_find_hi #(
        .N(N),
        .W(W)
    ) u_find_hi (
        .vec(pending),
        .idx(hi_idx),
        .any(hi_any)
    );

    // pending is cleared in IDLE, so y naturally reads 0 there.
    assign hi_mask   = N'(1) << hi_idx;
    assign remaining = pending & ~hi_mask;
    assign y         = hi_idx;
    assign busy      = (state == EMIT);
    assign valid     = (state == EMIT) && en && hi_any;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            done    <= 1'b0;
            none    <= 1'b0;
        end else begin
            done <= 1'b0;
            none <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            if (d != '0) begin
                                pending <= d;
                                state   <= EMIT;
                            end else begin
                                done <= 1'b1;
                                none <= 1'b1;
                            end
                        end
                    end
                    EMIT: begin
                        if (ready) begin
                            pending <= remaining;
                            if (remaining == '0) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
